// File: rtl/fir_decim_buf.sv
// fir_decim_buf
//   Decimator plus first-word-fall-through sample buffer sitting behind a FIR.
//   Every VIN cycle advances a phase counter. Only the sample taken at phase 0
//   is kept, so one sample in every DEC_eff samples is kept (DEC_eff = max(DEC,1)).
//   Kept samples enter a DEPTH-entry FIFO unchanged and are drained with a
//   VOUT/READY handshake. The FIR cannot be stalled. A kept sample that finds
//   the FIFO full, with no pop in the same cycle, is dropped and raises the
//   sticky OVF flag.
//
// Ports
//   CLK      in   clock, rising edge
//   RST_n    in   asynchronous active-low reset
//   DIN      in   DW-bit signed FIR sample
//   VIN      in   DIN valid (no backpressure)
//   DEC      in   4-bit decimation factor, 0 behaves as 1
//   DOUT     out  head-of-FIFO sample, 0 while VOUT=0
//   VOUT     out  FIFO not empty
//   READY    in   consumer takes DOUT on an edge where VOUT=1
//   LEVEL    out  FIFO occupancy, 0..DEPTH
//   OVF      out  sticky overflow flag
//   CLR_OVF  in   synchronous OVF clear (a same-cycle overflow takes priority)

module fir_decim_buf #(
    parameter int DW    = 13,
    parameter int DEPTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic signed [DW-1:0]    DIN,
    input  logic                    VIN,
    input  logic [3:0]              DEC,
    output logic signed [DW-1:0]    DOUT,
    output logic                    VOUT,
    input  logic                    READY,
    output logic [$clog2(DEPTH):0]  LEVEL,
    output logic                    OVF,
    input  logic                    CLR_OVF
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // ------------------------------------------------------------------
    // Decimation phase
    // ------------------------------------------------------------------
    logic [3:0] dec_r;
    logic [3:0] ph;
    logic [3:0] ph_nxt;
    logic [3:0] dec_sel;
    logic [3:0] dec_eff;
    logic [3:0] ph_base;
    logic       dec_chg;
    logic       keep;

    always_comb begin
        dec_chg = (DEC != dec_r);
        // A factor change takes effect in the same cycle. Phase restarts at 0,
        // so a sample arriving in that cycle is kept.
        dec_sel = dec_chg ? DEC : dec_r;
        dec_eff = (dec_sel == 4'd0) ? 4'd1 : dec_sel;
        ph_base = dec_chg ? 4'd0 : ph;
        keep    = VIN && (ph_base == 4'd0);
        ph_nxt  = ph_base;
        if (VIN) begin
            if (ph_base >= dec_eff - 4'd1)
                ph_nxt = 4'd0;
            else
                ph_nxt = ph_base + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            dec_r <= 4'd1;
            ph    <= 4'd0;
        end else begin
            dec_r <= DEC;
            ph    <= ph_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic signed [DW-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        count;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic                 ovf_evt;

    always_comb begin
        full    = (count == LW'(DEPTH));
        VOUT    = (count != '0);
        pop     = VOUT && READY;
        // When the FIFO is full, a pop in the same cycle frees the slot the new sample needs.
        push    = keep && (!full || pop);
        ovf_evt = keep && full && !pop;
        DOUT    = VOUT ? mem[rd_ptr] : '0;
        LEVEL   = count;
    end

    // Storage has no reset. The empty flag gates every read.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= DIN;
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // A set and a clear in the same cycle leave OVF at 1.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            OVF <= 1'b0;
        else if (ovf_evt)
            OVF <= 1'b1;
        else if (CLR_OVF)
            OVF <= 1'b0;
    end

endmodule

// File: doc/fir_decim_buf.md
FIR_DECIM_BUF -- requirements
Module: fir_decim_buf

Interface
REQ-001 SHALL have parameter DW, default 13, meaning sample width in bits (two's complement).
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, >= 2).
REQ-003 SHALL have port CLK, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port RST_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port DIN, input, DW bits signed: FIR output sample.
REQ-006 SHALL have port VIN, input, 1 bit: DIN valid this cycle; no backpressure toward the FIR.
REQ-007 SHALL have port DEC, input, 4 bits: decimation factor; 0 treated as 1.
REQ-008 SHALL have port DOUT, output, DW bits signed: head-of-FIFO sample.
REQ-009 SHALL have port VOUT, output, 1 bit: DOUT valid (FIFO not empty).
REQ-010 SHALL have port READY, input, 1 bit: consumer accepts DOUT when VOUT=1.
REQ-011 SHALL have port LEVEL, output, clog2(DEPTH)+1 bits: current occupancy, 0..DEPTH.
REQ-012 SHALL have port OVF, output, 1 bit: sticky overflow flag.
REQ-013 SHALL have port CLR_OVF, input, 1 bit: synchronous clear of OVF.

Function
REQ-014 SHALL keep phase counter PH; each VIN=1 cycle: sample kept iff PH==0; PH increments, wraps to 0 after DEC_eff-1 (DEC_eff = max(DEC,1)).
REQ-015 SHALL register DEC internally; when input DEC differs from registered value, SHALL load new value and clear PH to 0 that cycle (a VIN in that cycle is kept).
REQ-016 SHALL write a kept sample into the FIFO unmodified (no rounding, no width change).
REQ-017 SHALL be first-word-fall-through: sample kept at edge n is visible on DOUT with VOUT=1 after edge n (cycle n+1) if FIFO was empty.
REQ-018 SHALL pop the head on a rising edge when VOUT=1 and READY=1; READY with VOUT=0 has no effect.
REQ-019 SHALL drive DOUT=0 whenever VOUT=0.
REQ-020 SHALL preserve sample order exactly; pointers wrap modulo DEPTH.
REQ-021 When full and a kept sample arrives with no pop that cycle: SHALL drop the sample, leave contents unchanged, set OVF=1.
REQ-022 When full and a kept sample arrives with a pop in the same cycle: SHALL accept the sample, LEVEL stays DEPTH, OVF unchanged.
REQ-023 When empty, push and READY=1 same cycle: SHALL push only (no pop, since VOUT=0); LEVEL becomes 1.
REQ-024 LEVEL SHALL equal pushes minus pops, updated on the same edge.
REQ-025 OVF SHALL clear on CLR_OVF=1; a simultaneous overflow event SHALL win (OVF=1).
REQ-026 Discarded (non-kept) samples SHALL never set OVF.

Reset
REQ-027 RST_n=0 SHALL immediately force: PH=0, registered DEC=1, FIFO empty, VOUT=0, DOUT=0, LEVEL=0, OVF=0.
REQ-028 Reset mid-operation SHALL discard all buffered samples; the first VIN after release is kept.
REQ-029 SHALL exit reset synchronously on the first rising edge with RST_n=1; no input sampled while RST_n=0.

Verification
REQ-030 DEC=1, READY=1, VIN every cycle, DIN=1,2,3,... -> DOUT=1,2,3,... in order, VOUT continuous from 1 cycle after first VIN, LEVEL <= 1.
REQ-031 DEC=3, READY=1, DIN=10,11,...,21 every cycle -> DOUT sequence 10,13,16,19; OVF=0.
REQ-032 DEC=1, READY=0, 10 consecutive VIN with DIN=-4096..-4087 -> LEVEL=8, OVF=1 after 9th VIN; then READY=1 -> DOUT=-4096..-4089, samples 9,10 absent.
REQ-033 FIFO full, READY=1 and kept VIN same cycle -> LEVEL stays 8, OVF stays 0, new sample emerges after the 8 older ones.
REQ-034 DEC changed 4->2 when PH=2 -> the VIN in the change cycle is kept, then every 2nd VIN kept.
REQ-035 RST_n pulsed low with LEVEL=5, OVF=1 -> VOUT=0, DOUT=0, LEVEL=0, OVF=0 immediately; next VIN sample is output first.
